// File: rtl/reg_file_pkg.sv
// Register file shared constants.
// Widths, register count and MIPS-style register index names.
package reg_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

  // Assembler names for the general registers.
  localparam int AT = 1;
  localparam int V0 = 2;
  localparam int V1 = 3;
  localparam int A0 = 4;
  localparam int A1 = 5;
  localparam int A2 = 6;
  localparam int A3 = 7;
  localparam int T0 = 8;
  localparam int T1 = 9;
  localparam int T2 = 10;
  localparam int T3 = 11;
  localparam int T4 = 12;
  localparam int T5 = 13;
  localparam int T6 = 14;
  localparam int T7 = 15;
  localparam int S0 = 16;
  localparam int S1 = 17;
  localparam int S2 = 18;
  localparam int S3 = 19;
  localparam int S4 = 20;
  localparam int S5 = 21;
  localparam int S6 = 22;
  localparam int S7 = 23;
  localparam int T8 = 24;
  localparam int T9 = 25;
  localparam int K0 = 26;
  localparam int K1 = 27;
  localparam int GP = 28;
  localparam int SP = 29;
  localparam int FP = 30;
  localparam int RA = 31;

endpackage

// File: rtl/reg_file.sv
// General register array with HI/LO pair.
// Two operand read ports plus one debug read port, all combinational.
module reg_file #(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic                  hilo_write,
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  import reg_file_pkg::*;

  localparam int NREGS = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX =
    ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  wr_en;

  // Index 0 is hardwired, so its writes are dropped here.
  assign wr_en = reg_write && (write_reg != ZERO_IDX);

  // Array update: reset clears everything, else one write per edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  // HI/LO pair update, independent of the array write.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_write) begin
      hi_q <= hi_in;
      lo_q <= lo_in;
    end
  end

  // Reads come straight from storage; no write-through bypass.
  assign read_data1 = (read_reg1 == ZERO_IDX)
                    ? '0 : regs[read_reg1];
  assign read_data2 = (read_reg2 == ZERO_IDX)
                    ? '0 : regs[read_reg2];
  assign dbg_data   = (dbg_addr == ZERO_IDX)
                    ? '0 : regs[dbg_addr];

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam int S_RD1 = 0;
  localparam int S_RD2 = 1;
  localparam int S_DBG = 2;
  localparam int S_HI  = 3;
  localparam int S_LO  = 4;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } chk_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [AW-1:0] read_reg1;
  logic [AW-1:0] read_reg2;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic          hilo_write;
  logic [DW-1:0] hi_in;
  logic [DW-1:0] lo_in;
  logic [DW-1:0] hi_out;
  logic [DW-1:0] lo_out;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .hilo_write (hilo_write),
    .hi_in      (hi_in),
    .lo_in      (lo_in),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic push(input string n, input int s,
                      input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.sig  = s;
    c.exp  = e;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are settled mid-cycle, compare pending entries.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        chk_t        c;
        logic [31:0] act;
        c = sb.pop_front();
        case (c.sig)
          S_RD1:   act = read_data1;
          S_RD2:   act = read_data2;
          S_DBG:   act = dbg_data;
          S_HI:    act = hi_out;
          default: act = lo_out;
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h",
                   c.name, act, c.exp);
        end
      end
    end
  end

  // Watchdog against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    reset      = 1'b1;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = '0;
    read_reg2  = '0;
    hilo_write = 1'b0;
    hi_in      = '0;
    lo_in      = '0;
    dbg_addr   = '0;
    tick();
    reset = 1'b0;

    // Every index reads zero after reset.
    push("rst_hi", S_HI, 32'h0);
    push("rst_lo", S_LO, 32'h0);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = AW'(i);
      read_reg2 = AW'(31 - i);
      dbg_addr  = AW'(i);
      push($sformatf("rst_rd1_r%0d", i), S_RD1, 32'h0);
      push($sformatf("rst_rd2_r%0d", 31 - i), S_RD2, 32'h0);
      push($sformatf("rst_dbg_r%0d", i), S_DBG, 32'h0);
      tick();
    end

    // Write r5; old value visible until the edge.
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'hDEADBEEF;
    read_reg1  = 5'd5;
    push("r5_pre", S_RD1, 32'h0);
    tick();
    reg_write = 1'b0;
    read_reg1 = 5'd5;
    read_reg2 = 5'd5;
    push("r5_rd1", S_RD1, 32'hDEADBEEF);
    push("r5_rd2", S_RD2, 32'hDEADBEEF);
    tick();

    // Write to r0 is discarded.
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'h12345678;
    tick();
    reg_write = 1'b0;
    read_reg1 = 5'd0;
    dbg_addr  = 5'd0;
    push("r0_rd1", S_RD1, 32'h0);
    push("r0_dbg", S_DBG, 32'h0);
    tick();

    // No bypass on r7.
    reg_write  = 1'b1;
    write_reg  = 5'd7;
    write_data = 32'h1;
    tick();
    write_data = 32'h2;
    read_reg1  = 5'd7;
    push("r7_before", S_RD1, 32'h1);
    tick();
    reg_write = 1'b0;
    push("r7_after", S_RD1, 32'h2);
    tick();

    // Hold: r3 unaffected by a write to r4; HI/LO hold too.
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'hAAAA5555;
    hilo_write = 1'b1;
    hi_in      = 32'h11110000;
    lo_in      = 32'h00002222;
    tick();
    write_reg  = 5'd4;
    write_data = 32'h0F0F0F0F;
    hilo_write = 1'b0;
    hi_in      = 32'hFFFFFFFF;
    lo_in      = 32'hFFFFFFFF;
    tick();
    reg_write = 1'b0;
    read_reg1 = 5'd3;
    read_reg2 = 5'd4;
    dbg_addr  = 5'd5;
    push("hold_r3", S_RD1, 32'hAAAA5555);
    push("hold_r4", S_RD2, 32'h0F0F0F0F);
    push("hold_r5", S_DBG, 32'hDEADBEEF);
    push("hold_hi", S_HI, 32'h11110000);
    push("hold_lo", S_LO, 32'h00002222);
    tick();

    // Reset wins over same-edge writes.
    reg_write  = 1'b1;
    write_reg  = 5'd9;
    write_data = 32'h55;
    hilo_write = 1'b1;
    hi_in      = 32'h77;
    lo_in      = 32'h88;
    tick();
    read_reg1  = 5'd9;
    push("pre_rst_r9", S_RD1, 32'h55);
    push("pre_rst_hi", S_HI, 32'h77);
    push("pre_rst_lo", S_LO, 32'h88);
    reset      = 1'b1;
    write_data = 32'hFF;
    hi_in      = 32'hA;
    lo_in      = 32'hB;
    tick();
    reset      = 1'b0;
    reg_write  = 1'b0;
    hilo_write = 1'b0;
    read_reg1  = 5'd9;
    read_reg2  = 5'd5;
    dbg_addr   = 5'd7;
    push("mid_rst_r9", S_RD1, 32'h0);
    push("mid_rst_r5", S_RD2, 32'h0);
    push("mid_rst_r7", S_DBG, 32'h0);
    push("mid_rst_hi", S_HI, 32'h0);
    push("mid_rst_lo", S_LO, 32'h0);
    tick();

    // HI/LO and array write in one edge.
    reg_write  = 1'b1;
    write_reg  = 5'd31;
    write_data = 32'h3;
    hilo_write = 1'b1;
    hi_in      = 32'h1;
    lo_in      = 32'h2;
    tick();
    reg_write  = 1'b0;
    hilo_write = 1'b0;
    dbg_addr   = 5'd31;
    read_reg1  = 5'd31;
    read_reg2  = 5'd9;
    push("both_dbg_r31", S_DBG, 32'h3);
    push("both_rd1_r31", S_RD1, 32'h3);
    push("both_rd2_r9", S_RD2, 32'h0);
    push("both_hi", S_HI, 32'h1);
    push("both_lo", S_LO, 32'h2);
    tick();
    tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
